// File: rtl/music_seq_player_if.sv
// Bundle between the song player, its song ROM and the controlling logic.
// Optional feature macro: MUSIC_OCTAVE_SHIFT_EN adds the octave_shift input.
//
// Signalling: start and stop are single-cycle request pulses sampled on every
// rising clk edge; there is no ready. start is accepted only while the player
// is idle, stop is accepted in any state and wins over a simultaneous start.
// done is a one-cycle completion pulse on a natural song end. rom_data must
// hold the word addressed by rom_addr by the next rising edge (the player
// captures it at the end of its single fetch cycle). state_dbg mirrors the
// player FSM state (0 idle, 1 fetch, 2 play).
interface music_seq_player_if #(
  parameter int ADDR_W = 8
) ();
  logic              start;
  logic              stop;
  logic              loop_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [5:0]        rom_data;
  logic              speaker;
  logic              busy;
  logic              done;
  logic [1:0]        state_dbg;
`ifdef MUSIC_OCTAVE_SHIFT_EN
  logic [1:0]        octave_shift;

  modport master (
    output start, stop, loop_en, rom_data, octave_shift,
    input  rom_addr, speaker, busy, done, state_dbg
  );
  modport slave (
    input  start, stop, loop_en, rom_data, octave_shift,
    output rom_addr, speaker, busy, done, state_dbg
  );
`else
  modport master (
    output start, stop, loop_en, rom_data,
    input  rom_addr, speaker, busy, done, state_dbg
  );
  modport slave (
    input  start, stop, loop_en, rom_data,
    output rom_addr, speaker, busy, done, state_dbg
  );
`endif
endinterface

// File: rtl/music_seq_player.sv
// Song ROM sequencer: fetches one note code per slot, plays it as a square
// wave after a short silent articulation gap, detects the END marker or the
// last address, optionally loops, and pulses done on a natural end.
// Optional feature macro: MUSIC_OCTAVE_SHIFT_EN (per-note octave transpose).
module music_seq_player #(
  parameter int ADDR_W   = 8,
  parameter int SONG_LEN = 256,
  parameter int TICK_DIV = 4194304,
  parameter int GAP_DIV  = 16
) (
  input logic              clk,
  input logic              rst_n,
  music_seq_player_if.slave bus
);

  localparam int SLOT_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int GAP_LEN = TICK_DIV / GAP_DIV;
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(TICK_DIV - 1);
  localparam logic [SLOT_W-1:0] GAP_END   = SLOT_W'(GAP_LEN);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(SONG_LEN - 1);
  localparam logic [5:0] CODE_REST = 6'd0;
  localparam logic [5:0] CODE_END  = 6'd63;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_PLAY  = 2'd2
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [SLOT_W-1:0] slot_q;
  logic [17:0]       hp_q;
  logic [17:0]       hp_len_q;
  logic [17:0]       hp_fetch;
  logic              rest_q;
  logic              spk_q;
  logic              done_q;
  logic              done_d;
  logic              end_evt;
  logic [1:0]        shift;

`ifdef MUSIC_OCTAVE_SHIFT_EN
  assign shift = bus.octave_shift;
`else
  assign shift = 2'd0;
`endif

  // Half-period in clocks for a tone code: (BASE[idx]+1) * (256 >> octave),
  // with the octave raised by the transpose and saturated at 7.
  function automatic logic [17:0] half_period(input logic [5:0] code,
                                              input logic [1:0] sh);
    logic [2:0] oct;
    logic [3:0] idx;
    logic [3:0] sum;
    logic [2:0] eff;
    logic [8:0] base;
    oct = 3'(code / 6'd12);
    idx = 4'(code % 6'd12);
    sum = {1'b0, oct} + {2'b00, sh};
    eff = (sum > 4'd7) ? 3'd7 : sum[2:0];
    case (idx)
      4'd0:    base = 9'd511;
      4'd1:    base = 9'd482;
      4'd2:    base = 9'd455;
      4'd3:    base = 9'd430;
      4'd4:    base = 9'd405;
      4'd5:    base = 9'd383;
      4'd6:    base = 9'd361;
      4'd7:    base = 9'd341;
      4'd8:    base = 9'd322;
      4'd9:    base = 9'd303;
      4'd10:   base = 9'd286;
      4'd11:   base = 9'd270;
      default: base = 9'd511;
    endcase
    return (18'(base) + 18'd1) * (18'd256 >> eff);
  endfunction

  assign hp_fetch = half_period(bus.rom_data, shift);

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state, end-of-song detection and the done request; stop overrides.
  always_comb begin
    state_d = state_q;
    end_evt = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.stop) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (bus.stop)                       state_d = S_IDLE;
        else if (bus.rom_data == CODE_END)  end_evt = 1'b1;
        else                                state_d = S_PLAY;
      end
      S_PLAY: begin
        if (bus.stop) begin
          state_d = S_IDLE;
        end else if (slot_q == SLOT_LAST) begin
          if (addr_q == ADDR_LAST) end_evt = 1'b1;
          else                     state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (end_evt) begin
      state_d = bus.loop_en ? S_FETCH : S_IDLE;
      done_d  = !bus.loop_en;
    end
  end

  // Address, note latch, slot/half-period counters and speaker.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q   <= '0;
      slot_q   <= '0;
      hp_q     <= '0;
      hp_len_q <= '0;
      rest_q   <= 1'b0;
      spk_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= done_d;

      // Idle always parks at address 0; a loop restart also returns there.
      if (state_d == S_IDLE || end_evt)
        addr_q <= '0;
      else if (state_q == S_PLAY && state_d == S_FETCH)
        addr_q <= addr_q + ADDR_W'(1);

      // The fetched word is stable at the end of the fetch cycle.
      if (state_q == S_FETCH) begin
        hp_len_q <= hp_fetch;
        hp_q     <= hp_fetch - 18'd1;
        rest_q   <= (bus.rom_data == CODE_REST);
        slot_q   <= '0;
      end

      if (state_q == S_PLAY && state_d == S_PLAY) begin
        slot_q <= slot_q + SLOT_W'(1);
        // Silent gap (and rests) hold the half-period counter at reload so
        // the first toggle lands exactly one half-period after the gap.
        if (rest_q || slot_q < GAP_END) begin
          spk_q <= 1'b0;
          hp_q  <= hp_len_q - 18'd1;
        end else if (hp_q == 18'd0) begin
          spk_q <= ~spk_q;
          hp_q  <= hp_len_q - 18'd1;
        end else begin
          hp_q  <= hp_q - 18'd1;
        end
      end else begin
        spk_q <= 1'b0;
      end
    end
  end

  assign bus.rom_addr  = addr_q;
  assign bus.speaker   = spk_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = done_q;
  assign bus.state_dbg = state_q;

endmodule
